turf_udp_axil_bridge: RTL and testbench
=======================================

TURF_UDP_AXIL_BRIDGE -- requirements
Module: turf_udp_axil_bridge

Interface
REQ-001 Parameter TIMEOUT, default 255: max cycles waiting on any AXI channel before forced completion.
REQ-002 Parameter ERR_DATA, default 32'hFFFFFFFF: read data returned on timeout or error response.
REQ-003 aclk  in  1  single clock; all logic rising-edge.
REQ-004 aresetn  in  1  asynchronous, active-low reset.
REQ-005 en_i  in  1  request from UDP read/write engine; held until ack_o.
REQ-006 wr_i  in  1  1=write, 0=read; valid while en_i.
REQ-007 adr_i  in  28  register address; valid while en_i.
REQ-008 dat_i  in  32  write data; valid while en_i.
REQ-009 ack_o  out  1  one-cycle completion pulse.
REQ-010 dat_o  out  32  read data; valid in ack_o cycle, held until next ack_o.
REQ-011 m_axi_aw{addr[27:0],valid,ready}, m_axi_w{data[31:0],strb[3:0],valid,ready}, m_axi_b{resp[1:0],valid,ready}: AXI4-Lite write master channels.
REQ-012 m_axi_ar{addr[27:0],valid,ready}, m_axi_r{data[31:0],resp[1:0],valid,ready}: AXI4-Lite read master channels.
REQ-013 err_count_o  out  16  saturating count of timeouts plus non-OKAY responses.

Function
REQ-014 FSM states: IDLE, WR, WR_RESP, RD, RD_DATA, ACK.
REQ-015 IDLE, en_i=1: capture adr_i, wr_i, dat_i into registers; go WR (wr_i=1) or RD (wr_i=0); timeout counter cleared.
REQ-016 WR: awvalid and wvalid both asserted the cycle after capture; each deasserts independently the cycle after its own valid&ready; go WR_RESP once both handshakes complete (same-cycle completion allowed).
REQ-017 m_axi_wstrb fixed 4'hF; awaddr/araddr = captured address; wdata = captured data.
REQ-018 WR_RESP: bready=1; on bvalid go ACK; bresp!=OKAY increments err_count_o.
REQ-019 RD: arvalid asserted until arvalid&arready, then RD_DATA.
REQ-020 RD_DATA: rready=1; on rvalid latch dat_o = rdata (OKAY) or ERR_DATA (non-OKAY, err_count_o increments); go ACK.
REQ-021 ACK: ack_o=1 for exactly one cycle, then IDLE; minimum request-to-ack latency: write 3 cycles, read 3 cycles after capture cycle with zero-wait slave.
REQ-022 en_i sampled in ACK cycle is ignored; master drops en_i before the cycle after ack_o unless issuing a new request; a request present in IDLE is accepted (back-to-back allowed).
REQ-023 Timeout counter increments every cycle in WR, WR_RESP, RD, RD_DATA; on reaching TIMEOUT: all valid/ready outputs deasserted next cycle, dat_o=ERR_DATA for reads (unchanged for writes), err_count_o increments, go ACK.
REQ-024 Simultaneous timeout and handshake completion in the same cycle: handshake wins, no error counted.
REQ-025 err_count_o saturates at 16'hFFFF; never wraps.
REQ-026 At most one outstanding AXI transaction; no request accepted outside IDLE.
REQ-027 Changes of en_i/adr_i/dat_i after capture have no effect on the in-flight transaction.

Reset
REQ-028 aresetn low asynchronously forces IDLE; ack_o, all m_axi valid/ready outputs 0; dat_o 0; err_count_o 0; timeout counter 0; captured address/data 0.
REQ-029 Reset mid-transaction abandons it silently: no ack_o, no error counted; first capture on the first rising edge with aresetn high and en_i=1.

Verification
REQ-030 Write adr 0x0000000 data 0x12345678, slave always ready -> awaddr 0, wdata 0x12345678, wstrb F, single ack_o 3 cycles after capture, err_count_o 0.
REQ-031 Read adr 0x0000001, slave returns rdata 0xDEADBEEF OKAY after 2 wait cycles -> dat_o 0xDEADBEEF in ack_o cycle, single ack pulse.
REQ-032 Write with awready 4 cycles late, wready immediate -> wvalid drops after 1 cycle, awvalid held 5 cycles, bready only after both, one ack_o.
REQ-033 Read to non-responding slave, TIMEOUT=255 -> arvalid dropped, ack_o 256 cycles after capture, dat_o 0xFFFFFFFF, err_count_o 1.
REQ-034 Read with rresp SLVERR -> dat_o 0xFFFFFFFF, err_count_o increments; then write with bresp OKAY -> err_count_o unchanged.
REQ-035 aresetn pulsed low during WR_RESP -> bready/ack_o 0 immediately, no ack_o, err_count_o 0; next request completes normally.

Source files
------------

// File: rtl/turf_udp_axil_bridge.sv
// UDP register engine to AXI4-Lite master bridge.
// One transaction at a time, with a per-request timeout and an error counter.
module turf_udp_axil_bridge #(
    parameter int unsigned TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = 32'hFFFFFFFF
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        en_i,
    input  logic        wr_i,
    input  logic [27:0] adr_i,
    input  logic [31:0] dat_i,
    output logic        ack_o,
    output logic [31:0] dat_o,
    output logic [27:0] m_axi_awaddr,
    output logic        m_axi_awvalid,
    input  logic        m_axi_awready,
    output logic [31:0] m_axi_wdata,
    output logic [3:0]  m_axi_wstrb,
    output logic        m_axi_wvalid,
    input  logic        m_axi_wready,
    input  logic [1:0]  m_axi_bresp,
    input  logic        m_axi_bvalid,
    output logic        m_axi_bready,
    output logic [27:0] m_axi_araddr,
    output logic        m_axi_arvalid,
    input  logic        m_axi_arready,
    input  logic [31:0] m_axi_rdata,
    input  logic [1:0]  m_axi_rresp,
    input  logic        m_axi_rvalid,
    output logic        m_axi_rready,
    output logic [15:0] err_count_o
);

    typedef enum logic [2:0] {
        IDLE, WR, WR_RESP, RD, RD_DATA, ACK
    } state_t;

    localparam int unsigned TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT);

    state_t      r_state;
    logic [TW-1:0] r_tmo;
    logic [27:0] r_adr;
    logic [31:0] r_wdat;
    logic [31:0] r_dat;
    logic        r_ack;
    logic        r_awvalid;
    logic        r_wvalid;
    logic        r_bready;
    logic        r_arvalid;
    logic        r_rready;
    logic [15:0] r_err;

    logic        w_busy;
    logic        w_tmo;
    logic        w_aw_ok;
    logic        w_w_ok;
    logic        w_err_inc;

    assign w_busy  = (r_state == WR) || (r_state == WR_RESP) ||
                     (r_state == RD) || (r_state == RD_DATA);
    // Fires in the cycle the counter reaches TIMEOUT at the next edge.
    assign w_tmo   = w_busy && (r_tmo >= TMO_LAST);
    assign w_aw_ok = !r_awvalid || m_axi_awready;
    assign w_w_ok  = !r_wvalid || m_axi_wready;

    // Error events: non-OKAY responses, or a timeout not rescued by a handshake.
    always_comb begin
        w_err_inc = 1'b0;
        unique case (r_state)
            WR:      w_err_inc = w_tmo && !(w_aw_ok && w_w_ok);
            WR_RESP: w_err_inc = m_axi_bvalid ? (m_axi_bresp != 2'b00) : w_tmo;
            RD:      w_err_inc = w_tmo && !m_axi_arready;
            RD_DATA: w_err_inc = m_axi_rvalid ? (m_axi_rresp != 2'b00) : w_tmo;
            default: w_err_inc = 1'b0;
        endcase
    end

    // Saturating error counter.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_err <= 16'd0;
        end else if (w_err_inc && (r_err != 16'hFFFF)) begin
            r_err <= r_err + 16'd1;
        end
    end

    // Transaction FSM with registered channel controls.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state   <= IDLE;
            r_tmo     <= '0;
            r_adr     <= 28'd0;
            r_wdat    <= 32'd0;
            r_dat     <= 32'd0;
            r_ack     <= 1'b0;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_bready  <= 1'b0;
            r_arvalid <= 1'b0;
            r_rready  <= 1'b0;
        end else begin
            r_ack <= 1'b0;
            if (w_busy && (r_tmo != TMO_MAX)) begin
                r_tmo <= r_tmo + 1'b1;
            end
            unique case (r_state)
                IDLE: begin
                    if (en_i) begin
                        r_adr  <= adr_i;
                        r_wdat <= dat_i;
                        r_tmo  <= '0;
                        if (wr_i) begin
                            r_state   <= WR;
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                        end else begin
                            r_state   <= RD;
                            r_arvalid <= 1'b1;
                        end
                    end
                end
                WR: begin
                    if (m_axi_awready) r_awvalid <= 1'b0;
                    if (m_axi_wready)  r_wvalid  <= 1'b0;
                    if (w_aw_ok && w_w_ok) begin
                        r_state  <= WR_RESP;
                        r_bready <= 1'b1;
                    end else if (w_tmo) begin
                        r_awvalid <= 1'b0;
                        r_wvalid  <= 1'b0;
                        r_state   <= ACK;
                        r_ack     <= 1'b1;
                    end
                end
                WR_RESP: begin
                    if (m_axi_bvalid || w_tmo) begin
                        r_bready <= 1'b0;
                        r_state  <= ACK;
                        r_ack    <= 1'b1;
                    end
                end
                RD: begin
                    if (m_axi_arready) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= RD_DATA;
                    end else if (w_tmo) begin
                        r_arvalid <= 1'b0;
                        r_dat     <= ERR_DATA;
                        r_state   <= ACK;
                        r_ack     <= 1'b1;
                    end
                end
                RD_DATA: begin
                    if (m_axi_rvalid) begin
                        r_rready <= 1'b0;
                        r_dat    <= (m_axi_rresp == 2'b00) ? m_axi_rdata
                                                           : ERR_DATA;
                        r_state  <= ACK;
                        r_ack    <= 1'b1;
                    end else if (w_tmo) begin
                        r_rready <= 1'b0;
                        r_dat    <= ERR_DATA;
                        r_state  <= ACK;
                        r_ack    <= 1'b1;
                    end
                end
                ACK: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign ack_o         = r_ack;
    assign dat_o         = r_dat;
    assign m_axi_awaddr  = r_adr;
    assign m_axi_awvalid = r_awvalid;
    assign m_axi_wdata   = r_wdat;
    assign m_axi_wstrb   = 4'hF;
    assign m_axi_wvalid  = r_wvalid;
    assign m_axi_bready  = r_bready;
    assign m_axi_araddr  = r_adr;
    assign m_axi_arvalid = r_arvalid;
    assign m_axi_rready  = r_rready;
    assign err_count_o   = r_err;

endmodule

// File: tb/tb_turf_udp_axil_bridge.sv
// Bench for turf_udp_axil_bridge: vector table, delay-programmable
// AXI-Lite slave, and a scoreboard checked on every ack_o.
module tb_turf_udp_axil_bridge;

    typedef struct {
        bit          b2b;
        bit          wr;
        logic [27:0] adr;
        logic [31:0] dat;
        int          awd;
        int          wd;
        int          bd;
        int          ard;
        int          rd;
        bit          hang_b;
        bit          hang_ar;
        bit          hang_r;
        logic [1:0]  resp;
        logic [31:0] rdata;
        logic [31:0] exp_dat;
        int          exp_inc;
        int          exp_lat;
    } vec_t;

    typedef struct {
        logic [31:0] dat;
        logic [15:0] err;
        int          lat;
        int          base;
    } exp_t;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        en_i = 1'b0;
    logic        wr_i = 1'b0;
    logic [27:0] adr_i = '0;
    logic [31:0] dat_i = '0;
    logic        ack_o;
    logic [31:0] dat_o;
    logic [27:0] m_axi_awaddr;
    logic        m_axi_awvalid;
    logic        m_axi_awready;
    logic [31:0] m_axi_wdata;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_wvalid;
    logic        m_axi_wready;
    logic [1:0]  m_axi_bresp;
    logic        m_axi_bvalid;
    logic        m_axi_bready;
    logic [27:0] m_axi_araddr;
    logic        m_axi_arvalid;
    logic        m_axi_arready;
    logic [31:0] m_axi_rdata;
    logic [1:0]  m_axi_rresp;
    logic        m_axi_rvalid;
    logic        m_axi_rready;
    logic [15:0] err_count_o;

    turf_udp_axil_bridge dut (
        .aclk(aclk), .aresetn(aresetn),
        .en_i(en_i), .wr_i(wr_i), .adr_i(adr_i), .dat_i(dat_i),
        .ack_o(ack_o), .dat_o(dat_o),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid),
        .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
        .m_axi_bready(m_axi_bready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid),
        .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
        .err_count_o(err_count_o)
    );

    always #5 aclk = ~aclk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    always @(posedge aclk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    // Slave model
    vec_t cur;
    int   aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
    bit   aw_seen, w_seen, b_pend, r_pend;
    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;

    assign m_axi_awready = m_axi_awvalid && (aw_cnt >= cur.awd);
    assign m_axi_wready  = m_axi_wvalid && (w_cnt >= cur.wd);
    assign m_axi_arready = m_axi_arvalid && !cur.hang_ar &&
                           (ar_cnt >= cur.ard);
    assign m_axi_bvalid  = b_pend && !cur.hang_b && (b_cnt >= cur.bd);
    assign m_axi_rvalid  = r_pend && !cur.hang_r && (r_cnt >= cur.rd);
    assign m_axi_bresp   = cur.resp;
    assign m_axi_rresp   = cur.resp;
    assign m_axi_rdata   = cur.rdata;
    assign aw_hs = m_axi_awvalid && m_axi_awready;
    assign w_hs  = m_axi_wvalid && m_axi_wready;
    assign b_hs  = m_axi_bvalid && m_axi_bready;
    assign ar_hs = m_axi_arvalid && m_axi_arready;
    assign r_hs  = m_axi_rvalid && m_axi_rready;

    always @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; b_cnt <= 0; r_cnt <= 0;
            aw_seen <= 0; w_seen <= 0; b_pend <= 0; r_pend <= 0;
        end else begin
            aw_cnt <= (m_axi_awvalid && !m_axi_awready) ? aw_cnt + 1 : 0;
            w_cnt  <= (m_axi_wvalid && !m_axi_wready) ? w_cnt + 1 : 0;
            ar_cnt <= (m_axi_arvalid && !m_axi_arready) ? ar_cnt + 1 : 0;
            if (aw_hs) aw_seen <= 1;
            if (w_hs) w_seen <= 1;
            if ((aw_seen || aw_hs) && (w_seen || w_hs)) begin
                b_pend <= 1; aw_seen <= 0; w_seen <= 0;
            end
            if (b_pend && !m_axi_bvalid) b_cnt <= b_cnt + 1;
            if (b_hs) begin b_pend <= 0; b_cnt <= 0; end
            if (ar_hs) r_pend <= 1;
            if (r_pend && !m_axi_rvalid) r_cnt <= r_cnt + 1;
            if (r_hs) begin r_pend <= 0; r_cnt <= 0; end
            if (ack_o) begin
                aw_seen <= 0; w_seen <= 0; b_pend <= 0; r_pend <= 0;
                b_cnt <= 0; r_cnt <= 0;
            end
        end
    end

    // Scoreboard and protocol monitor
    exp_t        sb[$];
    exp_t        e;
    logic [27:0] exp_adr;
    logic [31:0] exp_wd;
    logic        prev_ack = 1'b0;

    always @(negedge aclk) begin
        if (aw_hs) chk("awaddr", m_axi_awaddr, exp_adr);
        if (w_hs) begin
            chk("wdata", m_axi_wdata, exp_wd);
            chk("wstrb", m_axi_wstrb, 4'hF);
        end
        if (ar_hs) chk("araddr", m_axi_araddr, exp_adr);
        if (aw_seen || w_seen)
            chk("valid_after_hs", {aw_seen & m_axi_awvalid,
                                   w_seen & m_axi_wvalid}, 2'b00);
        if (m_axi_bready) chk("bready_early", b_pend, 1'b1);
        if (m_axi_rready) chk("rready_early", r_pend, 1'b1);
        if (ack_o) begin
            chk("ack_single", prev_ack, 1'b0);
            chk("ack_chan_idle", {m_axi_awvalid, m_axi_wvalid,
                m_axi_bready, m_axi_arvalid, m_axi_rready}, 5'b0);
            if (sb.size() == 0) begin
                chk("ack_unexpected", 1'b1, 1'b0);
            end else begin
                e = sb.pop_front();
                chk("dat_o", dat_o, e.dat);
                chk("err_count", err_count_o, e.err);
                chk("latency", cyc - e.base, e.lat);
            end
        end
        prev_ack <= ack_o;
    end

    // Driver
    logic [31:0] model_dat = 32'd0;
    logic [15:0] model_err = 16'd0;

    task automatic run_entry(input vec_t v, input bit keep);
        int base;
        int n;
        exp_t x;
        if (!v.b2b) @(negedge aclk);
        base = v.b2b ? cyc + 1 : cyc;
        cur = v;
        en_i = 1'b1; wr_i = v.wr; adr_i = v.adr; dat_i = v.dat;
        exp_adr = v.adr; exp_wd = v.dat;
        if (!v.wr) model_dat = v.exp_dat;
        if (v.exp_inc != 0 && model_err != 16'hFFFF) model_err++;
        x.dat = model_dat; x.err = model_err;
        x.lat = v.exp_lat; x.base = base;
        sb.push_back(x);
        while (cyc < base + 1) @(negedge aclk);
        adr_i = 28'($urandom);
        dat_i = $urandom;
        n = 0;
        while (!ack_o && n < 600) begin
            @(negedge aclk);
            n++;
        end
        if (!ack_o) begin
            chk("ack_timeout", 1'b0, 1'b1);
            sb.delete();
        end
        if (!keep) en_i = 1'b0;
    endtask

    vec_t tab[13];
    vec_t post;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // b2b wr adr dat awd wd bd ard rd hb har hr resp rdata expdat inc lat
        tab[0]  = '{0,1,28'h0,32'h12345678,0,0,0,0,0,0,0,0,
                    2'd0,32'h0,32'h0,0,3};
        tab[1]  = '{0,0,28'h1,32'h0,0,0,0,0,2,0,0,0,
                    2'd0,32'hDEADBEEF,32'hDEADBEEF,0,5};
        tab[2]  = '{0,1,28'h10,32'hA5A5A5A5,4,0,0,0,0,0,0,0,
                    2'd0,32'h0,32'h0,0,7};
        tab[3]  = '{0,1,28'hABCDEF0,32'h0F0F0F0F,1,3,2,0,0,0,0,0,
                    2'd0,32'h0,32'h0,0,8};
        tab[4]  = '{0,0,28'h100,32'h0,0,0,0,0,0,0,1,0,
                    2'd0,32'h0,32'hFFFFFFFF,1,256};
        tab[5]  = '{0,0,28'h2,32'h0,0,0,0,0,0,0,0,0,
                    2'd2,32'h11111111,32'hFFFFFFFF,1,3};
        tab[6]  = '{0,1,28'h3,32'hCAFEF00D,0,0,0,0,0,0,0,0,
                    2'd0,32'h0,32'h0,0,3};
        tab[7]  = '{1,0,28'h4,32'h0,0,0,0,1,0,0,0,0,
                    2'd0,32'h0BADF00D,32'h0BADF00D,0,4};
        tab[8]  = '{1,1,28'h5,32'h5555AAAA,0,0,0,0,0,0,0,0,
                    2'd3,32'h0,32'h0,1,3};
        tab[9]  = '{0,1,28'h6,32'h77777777,0,0,0,0,0,1,0,0,
                    2'd0,32'h0,32'h0,1,256};
        tab[10] = '{0,0,28'h7,32'h0,0,0,0,0,0,0,0,1,
                    2'd0,32'h0,32'hFFFFFFFF,1,256};
        tab[11] = '{0,0,28'h8,32'h0,0,0,0,0,253,0,0,0,
                    2'd0,32'h600DCAFE,32'h600DCAFE,0,256};
        tab[12] = '{0,1,28'h9,32'h99999999,0,0,253,0,0,0,0,0,
                    2'd0,32'h0,32'h0,0,256};
        post    = '{0,0,28'hA,32'h0,0,0,0,0,0,0,0,0,
                    2'd0,32'h13579BDF,32'h13579BDF,0,3};
        cur = tab[0];

        repeat (3) @(negedge aclk);
        chk("rst_ack", ack_o, 1'b0);
        chk("rst_dat", dat_o, 32'h0);
        chk("rst_err", err_count_o, 16'h0);
        chk("rst_chan", {m_axi_awvalid, m_axi_wvalid, m_axi_bready,
                         m_axi_arvalid, m_axi_rready}, 5'b0);
        chk("rst_addr", m_axi_awaddr, 28'h0);
        aresetn = 1'b1;

        for (int i = 0; i < 13; i++) begin
            run_entry(tab[i], (i < 12) && tab[i+1].b2b);
        end

        // Reset while waiting for the write response
        @(negedge aclk);
        cur = tab[0];
        cur.bd = 20;
        en_i = 1'b1; wr_i = 1'b1; adr_i = 28'h55; dat_i = 32'h1;
        exp_adr = 28'h55; exp_wd = 32'h1;
        repeat (4) @(negedge aclk);
        chk("pre_rst_bready", m_axi_bready, 1'b1);
        #2 aresetn = 1'b0;
        #1;
        chk("mid_rst_bready", m_axi_bready, 1'b0);
        chk("mid_rst_ack", ack_o, 1'b0);
        chk("mid_rst_err", err_count_o, 16'h0);
        chk("mid_rst_dat", dat_o, 32'h0);
        en_i = 1'b0;
        model_err = 16'h0;
        model_dat = 32'h0;
        repeat (3) @(negedge aclk);
        aresetn = 1'b1;
        repeat (5) @(negedge aclk);
        chk("post_rst_idle", {ack_o, m_axi_awvalid, m_axi_bready}, 3'b0);
        run_entry(post, 1'b0);
        repeat (5) @(negedge aclk);
        chk("sb_empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
